// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-keyboard command sequencer (reset 0xFF, LED 0xED+arg) and receive-stream arbiter.
// Define PS2_INIT_ON_RESET_EN to launch the keyboard reset sequence automatically on Reset release.
module ps2_cmd_sequencer #(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       led_req,
    input  logic [2:0] led_value,
    input  logic       kbd_reset_req,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] fwd_data,
    output logic       fwd_data_en,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LAST    = TW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_LED     = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT     = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TX, S_RXWAIT, S_BATWAIT, S_RETRY, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        STEP_RST, STEP_LED, STEP_ARG
    } step_t;

    state_t        state;
    step_t         step;
    logic [2:0]    led_q;
    logic [RW-1:0] retry;
    logic [TW-1:0] timer;
    logic          pend_ack;
    logic          init_req;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [7:0]    cmd_byte;

`ifdef PS2_INIT_ON_RESET_EN
    logic init_pend;

    always_ff @(posedge CLOCK_50) begin
        if (Reset)
            init_pend <= 1'b1;
        else if (state == S_IDLE)
            init_pend <= 1'b0;
    end

    assign init_req = init_pend;
`else
    assign init_req = 1'b0;
`endif

    // An ACK that collided with command_was_sent is replayed as the first RXWAIT byte.
    assign rx_valid = received_data_en || pend_ack;
    assign rx_byte  = pend_ack ? RSP_ACK : received_data;

    always_comb begin
        cmd_byte = CMD_RESET;
        case (step)
            STEP_LED: cmd_byte = CMD_LED;
            STEP_ARG: cmd_byte = {5'b0, led_q};
            default:  cmd_byte = CMD_RESET;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state        <= S_IDLE;
            step         <= STEP_RST;
            led_q        <= 3'b000;
            retry        <= '0;
            timer        <= '0;
            pend_ack     <= 1'b0;
            the_command  <= 8'h00;
            send_command <= 1'b0;
            fwd_data     <= 8'h00;
            fwd_data_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            fwd_data_en <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    fwd_data_en <= received_data_en;
                    fwd_data    <= received_data;
                    if (kbd_reset_req || init_req || led_req) begin
                        step  <= (kbd_reset_req || init_req) ? STEP_RST : STEP_LED;
                        led_q <= (kbd_reset_req || init_req) ? led_q : led_value;
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        error <= 1'b0;
                        retry <= '0;
                    end
                end
                S_LOAD: begin
                    the_command  <= cmd_byte;
                    send_command <= 1'b1;
                    pend_ack     <= 1'b0;
                    state        <= S_TX;
                end
                S_TX: begin
                    if (command_was_sent) begin
                        send_command <= 1'b0;
                        timer        <= '0;
                        pend_ack     <= received_data_en && (received_data == RSP_ACK);
                        state        <= S_RXWAIT;
                    end else if (error_communication_timed_out) begin
                        send_command <= 1'b0;
                        state        <= S_RETRY;
                    end
                end
                S_RXWAIT: begin
                    pend_ack <= 1'b0;
                    if (rx_valid && rx_byte == RSP_ACK) begin
                        retry <= '0;
                        case (step)
                            STEP_RST: begin
                                timer <= '0;
                                state <= S_BATWAIT;
                            end
                            STEP_LED: begin
                                step  <= STEP_ARG;
                                state <= S_LOAD;
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end else if (rx_valid && rx_byte == RSP_RESEND) begin
                        state <= S_RETRY;
                    end else if (timer == ACK_LAST) begin
                        state <= S_RETRY;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_BATWAIT: begin
                    if (received_data_en && received_data == RSP_BAT) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if ((received_data_en && received_data == RSP_BAT_ERR) ||
                                 timer == BAT_LAST) begin
                        error <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RETRY: begin
                    if (retry == RETRY_LIMIT) begin
                        error <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        retry <= retry + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_DONE, S_FAIL: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: forwarding table, directed sequences and a
// randomized keyboard/controller emulator scored against a script-level outcome model.
module tb_ps2_cmd_sequencer;
    localparam int ACK_T = 16;
    localparam int BAT_T = 40;
    localparam int MAXR  = 3;

    logic       CLOCK_50 = 1'b0;
    logic       Reset = 1'b1;
    logic       led_req = 1'b0;
    logic [2:0] led_value = 3'b000;
    logic       kbd_reset_req = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic [7:0] fwd_data;
    logic       fwd_data_en;
    logic       busy;
    logic       done;
    logic       error;

    ps2_cmd_sequencer #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAXR)) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .led_req(led_req), .led_value(led_value),
        .kbd_reset_req(kbd_reset_req), .the_command(the_command), .send_command(send_command),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .received_data(received_data), .received_data_en(received_data_en),
        .fwd_data(fwd_data), .fwd_data_en(fwd_data_en), .busy(busy), .done(done), .error(error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // One keyboard/controller reaction per transmitted byte; b0/b1 < 0 means no byte.
    typedef struct {
        bit tx_fail;
        int d0;
        int b0;
        int d1;
        int b1;
    } ent_t;

    typedef struct {
        bit         en;
        logic [7:0] data;
        bit         exp_en;
        logic [7:0] exp_data;
    } fwd_vec_t;

    ent_t       script[$];
    int         ev_at[$];
    int         ev_byte[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_tx[$];
    bit         exp_ok;
    int         done_cnt, fwd_viol, gap_bad, stab_bad;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int junk();
        case ($urandom_range(0, 4))
            0: return 'h5A;
            1: return 'h12;
            2: return 'hAA;
            3: return 'hFC;
            default: return 'h00;
        endcase
    endfunction

    // Outcome from the protocol rules alone: which bytes go out, and whether it ends in done.
    function automatic void model(input bit is_rst, input logic [2:0] lv);
        logic [7:0] seq[$];
        int   idx, fails, resp;
        bit   acked;
        ent_t e;
        exp_tx.delete();
        exp_ok = 1'b0;
        idx = 0;
        if (is_rst) seq.push_back(8'hFF);
        else begin
            seq.push_back(8'hED);
            seq.push_back({5'b0, lv});
        end
        foreach (seq[bi]) begin
            fails = 0;
            acked = 1'b0;
            while (!acked) begin
                if (idx >= script.size()) return;
                e = script[idx];
                idx++;
                exp_tx.push_back(seq[bi]);
                resp = -1;
                if (!e.tx_fail) begin
                    if (e.b0 == 'hFA || (e.b0 == 'hFE && e.d0 > 0)) resp = e.b0;
                    else if (!is_rst && (e.b1 == 'hFA || e.b1 == 'hFE)) resp = e.b1;
                end
                if (resp == 'hFA) acked = 1'b1;
                else begin
                    fails++;
                    if (fails > MAXR) return;
                end
            end
            if (is_rst) begin
                exp_ok = (e.b1 == 'hAA);
                return;
            end
        end
        exp_ok = 1'b1;
    endfunction

    task automatic gen_script(input bit is_rst);
        int   nf;
        ent_t e;
        script.delete();
        for (int b = 0; b < (is_rst ? 1 : 2); b++) begin
            nf = $urandom_range(0, MAXR + 1);
            for (int f = 0; f < nf; f++) begin
                e = '{1'b0, int'($urandom_range(0, 4)), -1, 5, -1};
                case ($urandom_range(0, 3))
                    0: e.tx_fail = 1'b1;
                    1: e.b0 = 'hFE;
                    2: e.b0 = -1;
                    default: begin
                        e.b0 = junk();
                        if (e.d0 == 0) e.d0 = 1;
                    end
                endcase
                script.push_back(e);
            end
            if (nf > MAXR) break;
            e = '{1'b0, int'($urandom_range(0, 4)), 'hFA, 5, -1};
            if (is_rst) begin
                case ($urandom_range(0, 3))
                    0: e.b1 = 'hFC;
                    1: e.b1 = -1;
                    default: e.b1 = 'hAA;
                endcase
            end else if ($urandom_range(0, 2) == 0) begin
                e.b0 = junk();
                e.d0 = $urandom_range(1, 3);
                e.b1 = 'hFA;
            end
            script.push_back(e);
        end
    endtask

    // Emulates PS2_Controller + keyboard until the sequence returns to idle.
    task automatic run_kbd(input int budget);
        int         txc;
        bit         saw, pulsed, finished;
        logic [7:0] held;
        ent_t       e;
        txc = 0; saw = busy; finished = 1'b0; held = 8'h00;
        done_cnt = 0; fwd_viol = 0; gap_bad = 0; stab_bad = 0;
        tx_log.delete(); ev_at.delete(); ev_byte.delete();
        for (int now = 0; now < budget && !finished; now++) begin
            command_was_sent = 1'b0;
            error_communication_timed_out = 1'b0;
            received_data_en = 1'b0;
            received_data = 8'h00;
            pulsed = 1'b0;
            if (send_command) begin
                if (txc == 0) held = the_command;
                else if (the_command !== held) stab_bad++;
                txc++;
                if (txc == 3) begin
                    txc = 0;
                    pulsed = 1'b1;
                    tx_log.push_back(the_command);
                    if (script.size() > 0) e = script.pop_front();
                    else e = '{1'b0, 0, -1, 0, -1};
                    if (e.tx_fail) error_communication_timed_out = 1'b1;
                    else begin
                        command_was_sent = 1'b1;
                        if (e.b0 >= 0) begin ev_at.push_back(now + e.d0); ev_byte.push_back(e.b0); end
                        if (e.b1 >= 0) begin ev_at.push_back(now + e.d0 + e.d1); ev_byte.push_back(e.b1); end
                    end
                end
            end
            for (int i = 0; i < ev_at.size(); i++) begin
                if (ev_at[i] == now) begin
                    received_data_en = 1'b1;
                    received_data = 8'(ev_byte[i]);
                    ev_at.delete(i);
                    ev_byte.delete(i);
                    break;
                end
            end
            tick();
            if (pulsed && send_command) gap_bad++;
            if (done) done_cnt++;
            if (fwd_data_en) fwd_viol++;
            if (busy) saw = 1'b1;
            else if (saw) finished = 1'b1;
        end
        command_was_sent = 1'b0;
        error_communication_timed_out = 1'b0;
        received_data_en = 1'b0;
        check("seq_finished_in_budget", finished, 1);
    endtask

    task automatic finish_seq(input string tag);
        int mism;
        mism = 0;
        if (tx_log.size() != exp_tx.size()) mism = 1;
        else foreach (tx_log[i]) if (tx_log[i] !== exp_tx[i]) mism++;
        check({tag, " tx_count"}, tx_log.size(), exp_tx.size());
        check({tag, " tx_bytes_wrong"}, mism, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " error"}, error, !exp_ok);
        check({tag, " done_pulses"}, done_cnt, exp_ok);
        check({tag, " fwd_during_seq"}, fwd_viol, 0);
        check({tag, " send_not_dropped"}, gap_bad, 0);
        check({tag, " cmd_unstable"}, stab_bad, 0);
    endtask

    task automatic start_seq(input bit is_rst, input logic [2:0] lv);
        led_value = lv;
        if (is_rst) kbd_reset_req = 1'b1;
        else led_req = 1'b1;
        tick();
        kbd_reset_req = 1'b0;
        led_req = 1'b0;
        check("start busy", busy, 1);
        check("start error_cleared", error, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fwd_vec_t   fv[6];
        bit         is_rst;
        logic [2:0] lv;
        logic       en_r;
        logic [7:0] d_r;
        int         sends;

        fv[0] = '{1'b1, 8'hE0, 1'b1, 8'hE0};
        fv[1] = '{1'b1, 8'h6B, 1'b1, 8'h6B};
        fv[2] = '{1'b0, 8'h11, 1'b0, 8'h00};
        fv[3] = '{1'b1, 8'hFA, 1'b1, 8'hFA};
        fv[4] = '{1'b1, 8'hAA, 1'b1, 8'hAA};
        fv[5] = '{1'b0, 8'h00, 1'b0, 8'h00};

        repeat (3) tick();
        check("rst the_command", the_command, 0);
        check("rst send_command", send_command, 0);
        check("rst fwd_data", fwd_data, 0);
        check("rst fwd_data_en", fwd_data_en, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        Reset = 1'b0;
        repeat (3) tick();
        check("idle after release busy", busy, 0);
        check("idle after release send", send_command, 0);

        foreach (fv[i]) begin
            received_data = fv[i].data;
            received_data_en = fv[i].en;
            tick();
            check($sformatf("fwd_tab[%0d] en", i), fwd_data_en, fv[i].exp_en);
            if (fv[i].exp_en) check($sformatf("fwd_tab[%0d] data", i), fwd_data, fv[i].exp_data);
        end

        for (int i = 0; i < 40; i++) begin
            en_r = 1'($urandom_range(0, 1));
            d_r = 8'($urandom_range(0, 255));
            received_data = d_r;
            received_data_en = en_r;
            tick();
            check("fwd_rand en", fwd_data_en, en_r);
            if (en_r) check("fwd_rand data", fwd_data, d_r);
        end
        received_data_en = 1'b0;

        // LED 3'b101: junk 0x5A during the wait, second ACK collides with command_was_sent.
        script.delete();
        script.push_back('{1'b0, 2, 'h5A, 4, 'hFA});
        script.push_back('{1'b0, 0, 'hFA, 5, -1});
        model(1'b0, 3'b101);
        led_value = 3'b101; led_req = 1'b1;
        received_data = 8'h33; received_data_en = 1'b1;
        tick();
        led_req = 1'b0; received_data_en = 1'b0;
        check("accept fwd_en", fwd_data_en, 1);
        check("accept fwd_data", fwd_data, 'h33);
        check("latency busy N+1", busy, 1);
        check("latency send low N+1", send_command, 0);
        tick();
        check("latency send N+2", send_command, 1);
        check("latency cmd N+2", the_command, 'hED);
        run_kbd(2000);
        finish_seq("led101");

        script.delete();
        script.push_back('{1'b0, 3, 'hFE, 5, -1});
        script.push_back('{1'b0, 3, 'hFA, 5, 'hAA});
        model(1'b1, 3'b000);
        start_seq(1'b1, 3'b000);
        run_kbd(2000);
        finish_seq("resend");

        script.delete();
        repeat (4) script.push_back('{1'b0, 0, -1, 5, -1});
        model(1'b0, 3'b010);
        start_seq(1'b0, 3'b010);
        run_kbd(2000);
        finish_seq("ack_timeout");

        script.delete();
        script.push_back('{1'b0, 1, 'hFA, 5, -1});
        script.push_back('{1'b0, 4, 'hFA, 5, -1});
        model(1'b0, 3'b111);
        start_seq(1'b0, 3'b111);
        run_kbd(2000);
        finish_seq("after_timeout");

        script.delete();
        script.push_back('{1'b1, 0, -1, 5, -1});
        script.push_back('{1'b0, 2, 'hFA, 5, 'hAA});
        model(1'b1, 3'b000);
        led_value = 3'b011; led_req = 1'b1; kbd_reset_req = 1'b1;
        tick();
        led_req = 1'b0; kbd_reset_req = 1'b0;
        run_kbd(2000);
        finish_seq("collision");

        script.delete();
        script.push_back('{1'b0, 2, 'hFA, 5, 'hFC});
        model(1'b1, 3'b000);
        start_seq(1'b1, 3'b000);
        run_kbd(2000);
        finish_seq("bat_error");

        script.delete();
        script.push_back('{1'b0, 2, 'hFA, 5, -1});
        model(1'b1, 3'b000);
        start_seq(1'b1, 3'b000);
        run_kbd(2000);
        finish_seq("bat_timeout");

        for (int n = 0; n < 24; n++) begin
            is_rst = 1'($urandom_range(0, 1));
            lv = 3'($urandom_range(0, 7));
            gen_script(is_rst);
            model(is_rst, lv);
            start_seq(is_rst, lv);
            run_kbd(3000);
            finish_seq($sformatf("rand%0d", n));
        end

        // Reset while waiting for the keyboard response.
        kbd_reset_req = 1'b1;
        tick();
        kbd_reset_req = 1'b0;
        for (int i = 0; i < 10 && !send_command; i++) tick();
        check("rst_mid send up", send_command, 1);
        tick();
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        repeat (2) tick();
        check("rst_mid waiting busy", busy, 1);
        Reset = 1'b1;
        tick();
        check("rst_mid send", send_command, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid the_command", the_command, 0);
        Reset = 1'b0;
        sends = 0;
        repeat (30) begin
            tick();
            if (send_command) sends++;
        end
        check("rst_mid no_send_after", sends, 0);
        check("rst_mid idle busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
